// File: rtl/pipe_share_arbiter.sv
// Round-robin, credit-limited sharing of one fixed-latency 1-bit datapath among NUM_REQ requesters.
// Define PIPE_SHARE_STATS_EN to add the stat_issued/stat_stall saturating counters.
module pipe_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 9,
  parameter int MAX_OUT = 3
) (
  input  logic               tau2015_clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_a,
  input  logic [NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0] gnt,
  output logic               dp_valid,
  output logic               dp_a,
  output logic               dp_b,
  input  logic               dp_result,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic               rsp_data,
  input  logic               drain,
  input  logic               flush,
  output logic               halted,
  output logic               busy
`ifdef PIPE_SHARE_STATS_EN
  ,
  output logic [31:0]        stat_issued,
  output logic [31:0]        stat_stall
`endif
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CRED_W = $clog2(MAX_OUT + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_OUT);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CRED_W-1:0]  cred_q [NUM_REQ];
  logic [CRED_W-1:0]  cred_d [NUM_REQ];
  logic [LATENCY:0]   tag_v_q, tag_v_d;
  logic [IDX_W-1:0]   tag_idx_q [LATENCY+1];
  logic               dp_a_q, dp_b_q;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               rsp_data_q, rsp_data_d;

  logic               grant_en, found;
  logic [IDX_W-1:0]   gnt_idx, cand;
  logic [NUM_REQ-1:0] elig, gnt_c;
  logic               ret_v, inc, dec;
  logic [IDX_W-1:0]   ret_idx;

  // Stage boundary: tag_v_q[0] is the issue register, tag_v_q[LATENCY] lines up with dp_result.
  assign ret_v    = tag_v_q[LATENCY];
  assign ret_idx  = tag_idx_q[LATENCY];
  assign grant_en = (state_q == ST_RUN) && !drain && !flush && !rst;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req[i] && (cred_q[i] != '0);
    end
  end

  always_comb begin
    found   = 1'b0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    gnt_c   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && grant_en && elig[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (found) gnt_c[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d       = ptr_q;
    tag_v_d     = {tag_v_q[LATENCY-1:0], found};
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (flush) begin
      ptr_d   = '0;
      tag_v_d = '0;
    end else begin
      if (found) ptr_d = IDX_W'((int'(gnt_idx) + 1) % NUM_REQ);
      if (ret_v) begin
        rsp_valid_d[ret_idx] = 1'b1;
        rsp_data_d           = dp_result;
      end
    end
  end

  // A grant and a return for the same requester in one cycle cancel out.
  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cred_d[i] = cred_q[i];
      inc       = ret_v && (ret_idx == IDX_W'(i));
      dec       = gnt_c[i];
      if (flush) begin
        cred_d[i] = CRED_MAX;
      end else if (inc && !dec) begin
        cred_d[i] = cred_q[i] + CRED_W'(1);
      end else if (dec && !inc) begin
        cred_d[i] = cred_q[i] - CRED_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = drain ? ST_HALT : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (drain) state_d = ST_DRAIN;
        ST_DRAIN: begin
          if (!drain)             state_d = ST_RUN;
          else if (!(|tag_v_q))   state_d = ST_HALT;
        end
        ST_HALT:  if (!drain) state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge tau2015_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      ptr_q       <= '0;
      tag_v_q     <= '0;
      dp_a_q      <= 1'b0;
      dp_b_q      <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cred_q[i] <= CRED_MAX;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tag_v_q     <= tag_v_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      for (int i = 0; i < NUM_REQ; i++) cred_q[i] <= cred_d[i];
      if (found) begin
        dp_a_q <= req_a[gnt_idx];
        dp_b_q <= req_b[gnt_idx];
      end
    end
  end

  // Tag indices are qualified by tag_v_q, so they need no reset.
  always_ff @(posedge tau2015_clk) begin
    tag_idx_q[0] <= gnt_idx;
    for (int k = 1; k <= LATENCY; k++) tag_idx_q[k] <= tag_idx_q[k-1];
  end

  assign gnt       = gnt_c;
  assign dp_valid  = tag_v_q[0];
  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign halted    = (state_q == ST_HALT);
  assign busy      = |tag_v_q;

`ifdef PIPE_SHARE_STATS_EN
  logic [31:0] stat_issued_q, stat_stall_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge tau2015_clk or posedge rst) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (tag_v_q[0]) stat_issued_q <= sat_inc(stat_issued_q);
      if ((|req) && !found && (state_q == ST_RUN)) stat_stall_q <= sat_inc(stat_stall_q);
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Bench for pipe_share_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_pipe_share_arbiter;
  localparam int N   = 4;
  localparam int LAT = 9;
  localparam int MO  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] req, req_a, req_b, gnt, rsp_valid;
  logic         dp_valid, dp_a, dp_b, dp_result, rsp_data;
  logic         drain, flush, halted, busy;
  int checks = 0;
  int failures = 0;

  // Datapath stand-in: result = a & b, LAT cycles after issue.
  logic [LAT-1:0] dpline = '0;
  always @(posedge clk) dpline <= {dpline[LAT-2:0], dp_a & dp_b};
  assign dp_result = dpline[LAT-1];

  pipe_share_arbiter #(.NUM_REQ(N), .LATENCY(LAT), .MAX_OUT(MO)) dut (
    .tau2015_clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .dp_valid(dp_valid), .dp_a(dp_a), .dp_b(dp_b), .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .drain(drain), .flush(flush),
    .halted(halted), .busy(busy)
  );

  // Reference model: outstanding ops as a queue with due cycles, credits as counts.
  typedef struct { int idx; bit d; int due; } op_t;
  op_t m_q[$];
  int  m_cred[N];
  int  m_ptr = 0;
  int  m_mode = 0;  // 0 run, 1 drain, 2 halt
  int  m_cyc = 0;
  logic [N-1:0] e_rsp_valid = '0;
  logic e_rsp_data = 1'b0, e_dp_valid = 1'b0, e_dp_a = 1'b0, e_dp_b = 1'b0;

  function automatic int model_pick();
    int i;
    if (rst || flush || drain || m_mode != 0) return -1;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (req[i] && m_cred[i] > 0) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int g;
    bit was_empty;
    if (rst) begin
      m_q.delete();
      for (int i = 0; i < N; i++) m_cred[i] = MO;
      m_ptr = 0; m_mode = 0;
      e_rsp_valid = '0; e_rsp_data = 1'b0;
      e_dp_valid = 1'b0; e_dp_a = 1'b0; e_dp_b = 1'b0;
    end else begin
      g = model_pick();
      was_empty = (m_q.size() == 0);
      e_rsp_valid = '0;
      if (flush) begin
        m_q.delete();
        for (int i = 0; i < N; i++) m_cred[i] = MO;
        m_ptr = 0; e_dp_valid = 1'b0;
        m_mode = drain ? 2 : 0;
      end else begin
        if (m_q.size() > 0 && m_q[0].due == m_cyc + 1) begin
          e_rsp_valid[m_q[0].idx] = 1'b1;
          e_rsp_data = m_q[0].d;
          m_cred[m_q[0].idx]++;
          void'(m_q.pop_front());
        end
        e_dp_valid = (g >= 0);
        if (g >= 0) begin
          m_cred[g]--;
          m_ptr = (g + 1) % N;
          e_dp_a = req_a[g]; e_dp_b = req_b[g];
          m_q.push_back('{g, req_a[g] & req_b[g], m_cyc + LAT + 2});
        end
        case (m_mode)
          0: if (drain) m_mode = 1;
          1: if (!drain) m_mode = 0; else if (was_empty) m_mode = 2;
          default: if (!drain) m_mode = 0;
        endcase
      end
      m_cyc++;
    end
  end

  task automatic start();
    rst = 1'b1; req = '0; req_a = '0; req_b = '0; drain = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; req_a = '1; req_b = '1; drain = 1'b0; flush = 1'b0;
    @(posedge clk); #4;
    checks++; if (gnt !== '0) begin failures++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if ({dp_valid, dp_a, dp_b} !== 3'b000) begin failures++; $display("FAIL reset_dp: got %b want 000", {dp_valid, dp_a, dp_b}); end
    checks++; if ({rsp_valid, rsp_data} !== 5'b0) begin failures++; $display("FAIL reset_rsp: got %b want 00000", {rsp_valid, rsp_data}); end
    checks++; if ({halted, busy} !== 2'b00) begin failures++; $display("FAIL reset_status: got %b want 00", {halted, busy}); end
  endtask

  task automatic test_single();
    start();
    for (int c = 0; c <= 12; c++) begin
      req = (c == 0) ? 4'b0001 : 4'b0000; req_a = '1; req_b = '1;
      #4;
      if (c == 0) begin
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt: got %b want 0001", gnt); end
      end
      if (c == 1) begin
        checks++; if ({dp_valid, dp_a, dp_b} !== 3'b111) begin failures++; $display("FAIL single_issue: got %b want 111", {dp_valid, dp_a, dp_b}); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy1: got %b want 1", busy); end
      end
      if (c == 2) begin
        checks++; if (dp_valid !== 1'b0) begin failures++; $display("FAIL single_dpv_idle: got %b want 0", dp_valid); end
      end
      if (c == 10) begin
        checks++; if (dp_result !== 1'b1) begin failures++; $display("FAIL single_dpres: got %b want 1", dp_result); end
      end
      if (c == 11) begin
        checks++; if ({rsp_valid, rsp_data} !== 5'b00011) begin failures++; $display("FAIL single_rsp: got %b want 00011", {rsp_valid, rsp_data}); end
      end else begin
        checks++; if (rsp_valid !== '0) begin failures++; $display("FAIL single_norsp c=%0d: got %b want 0000", c, rsp_valid); end
      end
      if (c == 12) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy0: got %b want 0", busy); end
      end
      next_cycle();
    end
  endtask

  task automatic test_rr();
    logic [N-1:0] e;
    start();
    for (int c = 0; c <= 40; c++) begin
      req = 4'b1111; req_a = 4'($urandom); req_b = 4'($urandom);
      #4;
      e = '0; e[c % N] = 1'b1;
      checks++; if (gnt !== e) begin failures++; $display("FAIL rr_gnt c=%0d: got %b want %b", c, gnt, e); end
      e = '0; if (c >= 11) e[(c - 11) % N] = 1'b1;
      checks++; if (rsp_valid !== e) begin failures++; $display("FAIL rr_rsp c=%0d: got %b want %b", c, rsp_valid, e); end
      next_cycle();
    end
  endtask

  task automatic test_credit();
    logic [N-1:0] e;
    start();
    for (int c = 0; c <= 16; c++) begin
      req = 4'b0001; req_a = '1; req_b = '0;
      #4;
      e = (c inside {0, 1, 2, 11, 12, 13}) ? 4'b0001 : 4'b0000;
      checks++; if (gnt !== e) begin failures++; $display("FAIL credit_gnt c=%0d: got %b want %b", c, gnt, e); end
      e = (c inside {11, 12, 13}) ? 4'b0001 : 4'b0000;
      checks++; if (rsp_valid !== e) begin failures++; $display("FAIL credit_rsp c=%0d: got %b want %b", c, rsp_valid, e); end
      next_cycle();
    end
  endtask

  task automatic test_drain();
    logic [N-1:0] e;
    start();
    for (int c = 0; c <= 21; c++) begin
      req = 4'b1111; req_a = 4'($urandom); req_b = 4'($urandom);
      drain = (c >= 5 && c < 20);
      #4;
      e = '0;
      if (c < 5) e[c % N] = 1'b1;
      if (c == 21) e = 4'b0010;
      checks++; if (gnt !== e) begin failures++; $display("FAIL drain_gnt c=%0d: got %b want %b", c, gnt, e); end
      e = '0; if (c >= 11 && c <= 15) e[(c - 11) % N] = 1'b1;
      checks++; if (rsp_valid !== e) begin failures++; $display("FAIL drain_rsp c=%0d: got %b want %b", c, rsp_valid, e); end
      checks++; if (halted !== (c >= 16 && c <= 20)) begin failures++; $display("FAIL drain_halted c=%0d: got %b want %b", c, halted, (c >= 16 && c <= 20)); end
      next_cycle();
    end
    drain = 1'b0;
  endtask

  task automatic test_flush();
    logic [N-1:0] e;
    start();
    for (int c = 0; c <= 19; c++) begin
      req = (c <= 9) ? 4'b0001 : 4'b0000; req_a = '1; req_b = '1;
      flush = (c == 4);
      #4;
      e = (c inside {0, 1, 2, 5, 6, 7}) ? 4'b0001 : 4'b0000;
      checks++; if (gnt !== e) begin failures++; $display("FAIL flush_gnt c=%0d: got %b want %b", c, gnt, e); end
      e = (c inside {16, 17, 18}) ? 4'b0001 : 4'b0000;
      if (c >= 6) begin
        checks++; if (rsp_valid !== e) begin failures++; $display("FAIL flush_rsp c=%0d: got %b want %b", c, rsp_valid, e); end
      end
      if (c == 5) begin
        checks++; if ({busy, halted} !== 2'b00) begin failures++; $display("FAIL flush_busy: got %b want 00", {busy, halted}); end
      end
      if (c == 16) begin
        checks++; if (rsp_data !== 1'b1) begin failures++; $display("FAIL flush_rspdata: got %b want 1", rsp_data); end
      end
      next_cycle();
    end
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [N-1:0] e;
    start();
    for (int c = 0; c <= 6; c++) begin
      req = 4'b1111; req_a = '1; req_b = '1;
      if (c < 6) next_cycle();
    end
    #2; rst = 1'b1; #1;
    checks++; if ({gnt, dp_valid, dp_a, dp_b} !== 7'b0) begin failures++; $display("FAIL arst_issue: got %b want 0000000", {gnt, dp_valid, dp_a, dp_b}); end
    checks++; if ({rsp_valid, rsp_data, halted, busy} !== 7'b0) begin failures++; $display("FAIL arst_status: got %b want 0000000", {rsp_valid, rsp_data, halted, busy}); end
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c <= 11; c++) begin
      #4;
      e = '0; e[c % N] = 1'b1;
      checks++; if (gnt !== e) begin failures++; $display("FAIL arst_gnt c=%0d: got %b want %b", c, gnt, e); end
      e = (c == 11) ? 4'b0001 : 4'b0000;
      checks++; if (rsp_valid !== e) begin failures++; $display("FAIL arst_rsp c=%0d: got %b want %b", c, rsp_valid, e); end
      next_cycle();
    end
  endtask

  task automatic test_random();
    int g;
    logic [N-1:0] eg;
    start();
    for (int c = 0; c < 3000; c++) begin
      req = 4'($urandom); req_a = 4'($urandom); req_b = 4'($urandom);
      flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) < 3) drain = ~drain;
      if (c >= 2980) drain = 1'b0;
      #4;
      g = model_pick(); eg = '0; if (g >= 0) eg[g] = 1'b1;
      checks++; if (gnt !== eg) begin failures++; $display("FAIL rand_gnt c=%0d: got %b want %b", c, gnt, eg); end
      checks++; if ({dp_valid, dp_a, dp_b} !== {e_dp_valid, e_dp_a, e_dp_b}) begin failures++; $display("FAIL rand_dp c=%0d: got %b want %b", c, {dp_valid, dp_a, dp_b}, {e_dp_valid, e_dp_a, e_dp_b}); end
      checks++; if (rsp_valid !== e_rsp_valid) begin failures++; $display("FAIL rand_rspv c=%0d: got %b want %b", c, rsp_valid, e_rsp_valid); end
      if (e_rsp_valid != '0) begin
        checks++; if (rsp_data !== e_rsp_data) begin failures++; $display("FAIL rand_rspd c=%0d: got %b want %b", c, rsp_data, e_rsp_data); end
      end
      checks++; if (halted !== (m_mode == 2)) begin failures++; $display("FAIL rand_halted c=%0d: got %b want %b", c, halted, (m_mode == 2)); end
      checks++; if (busy !== (m_q.size() != 0)) begin failures++; $display("FAIL rand_busy c=%0d: got %b want %b", c, busy, (m_q.size() != 0)); end
      next_cycle();
    end
    req = '0; flush = 1'b0; drain = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req = '0; req_a = '0; req_b = '0; drain = 1'b0; flush = 1'b0;
    test_reset();
    test_single();
    test_rr();
    test_credit();
    test_drain();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_share_arbiter.md
Name: pipe_share_arbiter

Overview:
- Shares one fixed-latency, 1-bit, 2-operand pipelined datapath (NAND/NOR feedback plus inverter-chain stage) among NUM_REQ requesters.
- Arbitrates round-robin with per-requester credit limits. Issues operands to the datapath and tracks in-flight tags through a LATENCY-deep shift register.
- Routes each returned result to its originating requester. Provides drain/halt sequencing and a synchronous flush, so the datapath can be quiesced for retiming or reconfiguration.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LATENCY, 9, datapath cycles from dp_valid to dp_result (1..32).
- MAX_OUT, 3, maximum in-flight operations per requester (1..7).

Ports:
- tau2015_clk  in   1        single clock; all state on rising edge.
- rst          in   1        asynchronous, active-high reset.
- req          in   NUM_REQ  request, level per requester.
- req_a        in   NUM_REQ  operand a, one bit per requester.
- req_b        in   NUM_REQ  operand b, one bit per requester.
- gnt          out  NUM_REQ  one-hot grant (combinational); req&gnt = accepted.
- dp_valid     out  1        registered issue strobe to datapath.
- dp_a         out  1        registered operand a.
- dp_b         out  1        registered operand b.
- dp_result    in   1        datapath result, valid exactly LATENCY cycles after dp_valid.
- rsp_valid    out  NUM_REQ  registered one-hot response strobe.
- rsp_data     out  1        registered response data.
- drain        in   1        level; request quiesce.
- flush        in   1        single-cycle synchronous abort.
- halted       out  1        1 in HALT state.
- busy         out  1        any op issued or in flight.

Behaviour:
- **Reset (async, rst=1):** gnt=0, dp_valid=0, dp_a=0, dp_b=0, rsp_valid=0, rsp_data=0, halted=0, busy=0. Tag pipeline cleared; all credits=MAX_OUT; RR pointer=0; FSM=RUN. Reset asserted mid-operation discards all in-flight ops; their results are never reported.
- **Grant:** in RUN only, and not in a flush cycle.
  - Eligible(i) = req[i] & credit[i]!=0.
  - gnt = first eligible at or after the RR pointer, wrapping modulo NUM_REQ; at most one bit set.
  - On grant, the pointer advances to granted+1 (mod NUM_REQ). With no grant, the pointer holds.
- **Issue:**
  - The grant cycle G registers dp_valid=1, dp_a=req_a[i], dp_b=req_b[i] for cycle G+1.
  - Tag {valid, index} enters the tracking shift register.
  - dp_valid=0 in any cycle not following a grant. dp_a/dp_b hold their last value when idle.
- **Return:**
  - dp_result is sampled in cycle G+1+LATENCY.
  - rsp_valid[i]=1 and rsp_data=dp_result are visible in cycle G+2+LATENCY, for one cycle.
  - Grant-to-response latency is LATENCY+2 cycles. Responses cannot be back-pressured.
- **Credits:**
  - Decrement on the edge ending the grant cycle.
  - Increment on the same edge that sets rsp_valid[i].
  - Grant and return for the same requester in one cycle: net unchanged.
  - Credit never exceeds MAX_OUT and never underflows; credit 0 masks the requester.
- **FSM:**
  - RUN: grants enabled. drain=1 → DRAIN.
  - DRAIN: no grants. When tracking is empty and dp_valid=0 → HALT.
  - HALT: halted=1, no grants. drain=0 → RUN (drain=0 in DRAIN also → RUN).
- **Flush (flush=1):**
  - No grant that cycle.
  - Next edge: tag valids cleared, dp_valid=0, credits=MAX_OUT, pointer=0, rsp_valid=0.
  - FSM goes to HALT if drain=1, else RUN.
  - Results of flushed ops are never reported.
- **Busy:** busy = dp_valid | any tag valid (registered-equivalent; 0 the cycle after flush or reset).
- **Simultaneous drain and flush:** flush takes priority; the result state is HALT.

Optional Feature:
- Macro: PIPE_SHARE_STATS_EN.
- Defined: adds outputs stat_issued[31:0] and stat_stall[31:0].
  - stat_issued increments per dp_valid.
  - stat_stall increments per cycle with |req=1 and gnt=0 while in RUN.
  - Both counters saturate at 2^32-1.
  - Cleared by rst only; flush does not clear them.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan (NUM_REQ=4, LATENCY=9, MAX_OUT=3; bench models the datapath as result=(a&b) delayed 9 cycles):
1. req=0001, a=1, b=1 at cycle 0 only -> gnt=0001 @0; dp_valid=1, dp_a=1, dp_b=1 @1; dp_result driven @10; rsp_valid=0001, rsp_data=1 @11; busy=0 @12.
2. req=1111 held -> gnt sequence 0001,0010,0100,1000 repeating @0..11 with no bubbles; req0 rsp @11 restores credit; gnt=0001 @12; no gnt bubble through cycle 40.
3. req=0001 held -> gnt @0,1,2; gnt=0 @3..10 (credit 0); rsp_valid @11,12,13; gnt @11,12,13.
4. req=1111 held, drain=1 from cycle 5 -> last gnt @4; rsp_valid continues through @15; halted=1 @16; drain=0 @20 -> gnt resumes @21.
5. req=0001 granted @0,1,2, flush=1 @4 -> no gnt @4; busy=0 and credit=3 @5; no rsp_valid @11..13; new grant @5 yields rsp @16.
6. rst pulsed asynchronously mid-cycle 6 with ops in flight -> all outputs 0 immediately; no rsp_valid afterwards; grants resume from requester 0 after release.
